wb_writeback_arbiter: RTL and testbench



---
 rtl/wb_writeback_arbiter_pkg.sv | 21 ++
 rtl/wb_writeback_arbiter_if.sv | 38 +++
 rtl/wb_result_fifo.sv | 49 ++++
 rtl/wb_writeback_arbiter.sv | 122 ++++++++++++
 tb/tb_wb_writeback_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_writeback_arbiter_pkg.sv
// Shared writeback definitions for the MEM/WB boundary and the register-file writer.
package wb_writeback_arbiter_pkg;

  localparam int unsigned N  = 32;
  localparam int unsigned RA = 5;

  localparam logic [RA-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic          valid;
    logic [RA-1:0] addr;
    logic [N-1:0]  data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_FIFO
  } wb_grant_e;

endpackage

// File: rtl/wb_writeback_arbiter_if.sv
// Bundle of pipeline, long-unit and register-file write signals around the writeback arbiter.
interface wb_writeback_arbiter_if #(
  parameter int unsigned N  = wb_writeback_arbiter_pkg::N,
  parameter int unsigned RA = wb_writeback_arbiter_pkg::RA
);

  logic          pipe_valid_M;
  logic [RA-1:0] pipe_addr_M;
  logic [N-1:0]  pipe_data_M;

  logic          lu_issue;
  logic [RA-1:0] lu_issue_addr;
  logic          lu_valid;
  logic [RA-1:0] lu_addr;
  logic [N-1:0]  lu_data;
  logic          lu_ready;

  logic          reg_we_W;
  logic [RA-1:0] reg_src3_W;
  logic [N-1:0]  reg_write_W;
  logic          stall_req;
  logic [31:0]   busy_mask;

  modport master (
    output pipe_valid_M, pipe_addr_M, pipe_data_M,
    output lu_issue, lu_issue_addr, lu_valid, lu_addr, lu_data,
    input  lu_ready,
    input  reg_we_W, reg_src3_W, reg_write_W, stall_req, busy_mask
  );

  modport slave (
    input  pipe_valid_M, pipe_addr_M, pipe_data_M,
    input  lu_issue, lu_issue_addr, lu_valid, lu_addr, lu_data,
    output lu_ready,
    output reg_we_W, reg_src3_W, reg_write_W, stall_req, busy_mask
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Small power-of-two result FIFO; pushes into a full FIFO and pops from an empty one are ignored.
module wb_result_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned W     = 37,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_writeback_arbiter.sv
// Register-file writer: merges MEM-stage results with queued long-latency results,
// tracks registers still owed by the long unit, and requests a stall when the queue starves.
module wb_writeback_arbiter #(
  parameter int unsigned N            = wb_writeback_arbiter_pkg::N,
  parameter int unsigned RA           = wb_writeback_arbiter_pkg::RA,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  rst,
  wb_writeback_arbiter_if.slave wb
);

  import wb_writeback_arbiter_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t       pipe_req;
  wb_req_t       head_req;
  wb_req_t       sel_req;
  wb_grant_e     grant;

  logic [RA+N-1:0] head_bits;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            pop;

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic          stall_q;
  logic          stall_d;
  logic [31:0]   busy_q;
  logic [31:0]   busy_d;
  logic          we_q;
  logic [RA-1:0] addr_q;
  logic [N-1:0]  data_q;

  assign pipe_req = '{valid: wb.pipe_valid_M, addr: wb.pipe_addr_M, data: wb.pipe_data_M};
  assign head_req = '{valid: !fifo_empty, addr: head_bits[N +: RA], data: head_bits[N-1:0]};

  // Readiness comes from the pre-pop occupancy so a full queue refuses even while draining.
  assign wb.lu_ready = (fifo_count < CW'(DEPTH));

  wb_result_fifo #(
    .DEPTH (DEPTH),
    .W     (RA + N)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wb.lu_valid && !fifo_full),
    .pop   (pop),
    .din   ({wb.lu_addr, wb.lu_data}),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    grant = GNT_NONE;
    if (stall_q) begin
      if (!fifo_empty) grant = GNT_FIFO;
    end else if (wb.pipe_valid_M) begin
      grant = GNT_PIPE;
    end else if (!fifo_empty) begin
      grant = GNT_FIFO;
    end
  end

  assign pop = (grant == GNT_FIFO);

  always_comb begin
    sel_req  = '0;
    starve_d = '0;
    stall_d  = 1'b0;
    busy_d   = busy_q;

    case (grant)
      GNT_PIPE: sel_req = pipe_req;
      GNT_FIFO: sel_req = head_req;
      default:  sel_req = '0;
    endcase

    // Reaching the limit fires a one-cycle stall and restarts the count.
    if (grant == GNT_PIPE && !fifo_empty) begin
      if (starve_q == SW'(STARVE_LIMIT - 1)) stall_d = 1'b1;
      else                                    starve_d = starve_q + SW'(1);
    end

    if (pop) busy_d[head_req.addr] = 1'b0;
    if (wb.lu_issue && wb.lu_issue_addr != ZERO_REG) busy_d[wb.lu_issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      stall_q  <= 1'b0;
      busy_q   <= '0;
      starve_q <= '0;
    end else begin
      we_q     <= sel_req.valid && (sel_req.addr != ZERO_REG);
      if (sel_req.valid) begin
        addr_q <= sel_req.addr;
        data_q <= sel_req.data;
      end
      stall_q  <= stall_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
    end
  end

  assign wb.reg_we_W    = we_q;
  assign wb.reg_src3_W  = addr_q;
  assign wb.reg_write_W = data_q;
  assign wb.stall_req   = stall_q;
  assign wb.busy_mask   = busy_q;

endmodule

// File: tb/tb_wb_writeback_arbiter.sv
// Scenario bench for wb_writeback_arbiter with a queue of expected register-file writes.
module tb_wb_writeback_arbiter;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  wb_writeback_arbiter_if #(.N(32), .RA(5)) wb ();

  wb_writeback_arbiter #(
    .N            (32),
    .RA           (5),
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_pipe(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb.pipe_valid_M = v;
    wb.pipe_addr_M  = a;
    wb.pipe_data_M  = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb.lu_valid = v;
    wb.lu_addr  = a;
    wb.lu_data  = d;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] a);
    wb.lu_issue      = v;
    wb.lu_issue_addr = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_pipe(1'b0, '0, '0);
    set_lu(1'b0, '0, '0);
    set_issue(1'b0, '0);
    tick();
    tick();
    n_checks++; if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b, required 0", wb.reg_we_W); end
    n_checks++; if (wb.reg_src3_W !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", wb.reg_src3_W); end
    n_checks++; if (wb.reg_write_W !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", wb.reg_write_W); end
    n_checks++; if (wb.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, required 0", wb.stall_req); end
    n_checks++; if (wb.busy_mask !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h, required 0", wb.busy_mask); end
    n_checks++; if (wb.lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", wb.lu_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pipe_write();
    exp_t e;
    set_pipe(1'b1, 5'd8, 32'hDEADBEEF);
    sb.push_back('{addr: 5'd8, data: 32'hDEADBEEF});
    tick();
    set_pipe(1'b0, '0, '0);
    n_checks++;
    if (wb.reg_we_W !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL pipe_we: got %b, required 1", wb.reg_we_W);
    end else begin
      e = sb.pop_front();
      if ({wb.reg_src3_W, wb.reg_write_W} !== {e.addr, e.data}) begin
        n_fail++; $display("FAIL pipe_write: got r%0d=%h, required r%0d=%h", wb.reg_src3_W, wb.reg_write_W, e.addr, e.data);
      end
    end
    tick();
    n_checks++; if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL pipe_we_drop: got %b, required 0", wb.reg_we_W); end
  endtask

  task automatic test_long_result();
    exp_t e;
    set_issue(1'b1, 5'd10);
    tick();
    set_issue(1'b0, '0);
    n_checks++; if (wb.busy_mask !== 32'h0000_0400) begin n_fail++; $display("FAIL lu_busy_set: got %h, required 00000400", wb.busy_mask); end
    set_lu(1'b1, 5'd10, 32'd5);
    n_checks++; if (wb.lu_ready !== 1'b1) begin n_fail++; $display("FAIL lu_ready_empty: got %b, required 1", wb.lu_ready); end
    sb.push_back('{addr: 5'd10, data: 32'd5});
    tick();
    set_lu(1'b0, '0, '0);
    n_checks++; if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL lu_early_write: got %b, required 0", wb.reg_we_W); end
    n_checks++; if (wb.busy_mask !== 32'h0000_0400) begin n_fail++; $display("FAIL lu_busy_hold: got %h, required 00000400", wb.busy_mask); end
    tick();
    n_checks++;
    if (wb.reg_we_W !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL lu_we: got %b, required 1", wb.reg_we_W);
    end else begin
      e = sb.pop_front();
      if ({wb.reg_src3_W, wb.reg_write_W} !== {e.addr, e.data}) begin
        n_fail++; $display("FAIL lu_write: got r%0d=%h, required r%0d=%h", wb.reg_src3_W, wb.reg_write_W, e.addr, e.data);
      end
    end
    n_checks++; if (wb.busy_mask !== 32'd0) begin n_fail++; $display("FAIL lu_busy_clear: got %h, required 0", wb.busy_mask); end
    tick();
    n_checks++; if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL lu_we_drop: got %b, required 0", wb.reg_we_W); end
  endtask

  // Pipeline stays busy while three long results arrive; row 5 is the stall cycle,
  // where the presented pipeline request (r6) is ignored and re-presented in row 6.
  task automatic test_fifo_starve();
    int pv  [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int pa  [10] = '{1, 2, 3, 4, 5, 6, 6, 0, 0, 0};
    int lv  [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int la  [10] = '{20, 21, 22, 22, 22, 22, 22, 0, 0, 0};
    int rdy [10] = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 1};
    int stl [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int wv  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int wa  [10] = '{1, 2, 3, 4, 5, 20, 6, 21, 22, 0};
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      set_pipe(pv[i] != 0, 5'(pa[i]), 32'hBEEF_0000 + 32'(pa[i]));
      set_lu(lv[i] != 0, 5'(la[i]), 32'hC0DE_0000 + 32'(la[i]));
      n_checks++;
      if (wb.lu_ready !== (rdy[i] != 0)) begin n_fail++; $display("FAIL starve_ready row %0d: got %b, required %0d", i, wb.lu_ready, rdy[i]); end
      n_checks++;
      if (wb.stall_req !== (stl[i] != 0)) begin n_fail++; $display("FAIL starve_stall row %0d: got %b, required %0d", i, wb.stall_req, stl[i]); end
      if (wv[i] != 0)
        sb.push_back('{addr: 5'(wa[i]), data: (wa[i] >= 20 ? 32'hC0DE_0000 : 32'hBEEF_0000) + 32'(wa[i])});
      tick();
      n_checks++;
      if (wb.reg_we_W) begin
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL starve_write row %0d: got r%0d=%h, required no write", i, wb.reg_src3_W, wb.reg_write_W);
        end else begin
          e = sb.pop_front();
          if ({wb.reg_src3_W, wb.reg_write_W} !== {e.addr, e.data}) begin
            n_fail++; $display("FAIL starve_write row %0d: got r%0d=%h, required r%0d=%h", i, wb.reg_src3_W, wb.reg_write_W, e.addr, e.data);
          end
        end
      end else if (wv[i] != 0) begin
        n_fail++; $display("FAIL starve_write row %0d: got no write, required r%0d", i, wa[i]);
        if (sb.size() != 0) sb.delete(0);
      end
    end
  endtask

  task automatic test_zero_reg();
    set_pipe(1'b1, 5'd0, 32'h1234_5678);
    tick();
    set_pipe(1'b0, '0, '0);
    n_checks++; if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL zero_pipe_we: got %b, required 0", wb.reg_we_W); end
    set_issue(1'b1, 5'd0);
    set_lu(1'b1, 5'd0, 32'd7);
    tick();
    set_issue(1'b0, '0);
    n_checks++; if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL zero_idle_we: got %b, required 0", wb.reg_we_W); end
    n_checks++; if (wb.busy_mask !== 32'd0) begin n_fail++; $display("FAIL zero_busy: got %h, required 0", wb.busy_mask); end
    set_lu(1'b1, 5'd0, 32'd8);
    n_checks++; if (wb.lu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready_1: got %b, required 1", wb.lu_ready); end
    tick();
    n_checks++; if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL zero_pop_we_1: got %b, required 0", wb.reg_we_W); end
    set_lu(1'b1, 5'd0, 32'd9);
    n_checks++; if (wb.lu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_pop_count: lu_ready got %b, required 1", wb.lu_ready); end
    tick();
    set_lu(1'b0, '0, '0);
    n_checks++; if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL zero_pop_we_2: got %b, required 0", wb.reg_we_W); end
    tick();
    n_checks++; if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL zero_pop_we_3: got %b, required 0", wb.reg_we_W); end
    tick();
    n_checks++; if (wb.lu_ready !== 1'b1) begin n_fail++; $display("FAIL zero_drained: lu_ready got %b, required 1", wb.lu_ready); end
    n_checks++; if (wb.busy_mask !== 32'd0) begin n_fail++; $display("FAIL zero_busy_end: got %h, required 0", wb.busy_mask); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      set_issue(1'b1, 5'(10 + i));
      set_pipe(1'b1, 5'(3 + i), 32'hAAAA_0000 + 32'(i));
      set_lu(1'b1, 5'(10 + i), 32'hBBBB_0000 + 32'(i));
      sb.push_back('{addr: 5'(3 + i), data: 32'hAAAA_0000 + 32'(i)});
      tick();
      n_checks++;
      if (wb.reg_we_W !== 1'b1 || sb.size() == 0) begin
        n_fail++; $display("FAIL rmid_pipe_we %0d: got %b, required 1", i, wb.reg_we_W);
      end else begin
        e = sb.pop_front();
        if ({wb.reg_src3_W, wb.reg_write_W} !== {e.addr, e.data}) begin
          n_fail++; $display("FAIL rmid_pipe_write %0d: got r%0d=%h, required r%0d=%h", i, wb.reg_src3_W, wb.reg_write_W, e.addr, e.data);
        end
      end
    end
    n_checks++; if (wb.busy_mask !== 32'h0000_0C00) begin n_fail++; $display("FAIL rmid_busy_pre: got %h, required 00000C00", wb.busy_mask); end
    n_checks++; if (wb.lu_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: lu_ready got %b, required 0", wb.lu_ready); end
    rst = 1'b1;
    set_issue(1'b0, '0);
    set_pipe(1'b0, '0, '0);
    set_lu(1'b0, '0, '0);
    #1;
    n_checks++; if (wb.busy_mask !== 32'd0) begin n_fail++; $display("FAIL rmid_async_busy: got %h, required 0", wb.busy_mask); end
    n_checks++; if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL rmid_async_we: got %b, required 0", wb.reg_we_W); end
    tick();
    n_checks++; if (wb.lu_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b, required 1", wb.lu_ready); end
    n_checks++; if ({wb.reg_src3_W, wb.reg_write_W, wb.stall_req} !== 38'd0) begin
      n_fail++; $display("FAIL rmid_outputs: got r%0d=%h stall=%b, required all 0", wb.reg_src3_W, wb.reg_write_W, wb.stall_req);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL rmid_discard %0d: got write r%0d=%h, required none", i, wb.reg_src3_W, wb.reg_write_W); end
    end
  endtask

  task automatic test_issue_pop_same();
    exp_t e;
    set_issue(1'b1, 5'd12);
    tick();
    set_issue(1'b0, '0);
    n_checks++; if (wb.busy_mask !== 32'h0000_1000) begin n_fail++; $display("FAIL same_busy_set: got %h, required 00001000", wb.busy_mask); end
    set_lu(1'b1, 5'd12, 32'h33);
    sb.push_back('{addr: 5'd12, data: 32'h33});
    tick();
    set_lu(1'b0, '0, '0);
    set_issue(1'b1, 5'd12);
    tick();
    set_issue(1'b0, '0);
    n_checks++;
    if (wb.reg_we_W !== 1'b1 || sb.size() == 0) begin
      n_fail++; $display("FAIL same_we: got %b, required 1", wb.reg_we_W);
    end else begin
      e = sb.pop_front();
      if ({wb.reg_src3_W, wb.reg_write_W} !== {e.addr, e.data}) begin
        n_fail++; $display("FAIL same_write: got r%0d=%h, required r%0d=%h", wb.reg_src3_W, wb.reg_write_W, e.addr, e.data);
      end
    end
    n_checks++; if (wb.busy_mask !== 32'h0000_1000) begin n_fail++; $display("FAIL same_busy_kept: got %h, required 00001000", wb.busy_mask); end
    tick();
    n_checks++; if (wb.reg_we_W !== 1'b0) begin n_fail++; $display("FAIL same_we_drop: got %b, required 0", wb.reg_we_W); end
    n_checks++; if (wb.busy_mask !== 32'h0000_1000) begin n_fail++; $display("FAIL same_busy_hold: got %h, required 00001000", wb.busy_mask); end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_long_result();
    test_fifo_starve();
    test_zero_reg();
    test_reset_mid();
    test_issue_pop_same();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: %0d expected writes left, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
